// File: rtl/terrain_pkg.sv
// terrain_pkg: shared constants, quadrant encoding and LFSR step for terrain_synth.
package terrain_pkg;
  typedef enum logic [1:0] {
    QUAD_RISE     = 2'b00,
    QUAD_FALL     = 2'b01,
    QUAD_NEG_RISE = 2'b10,
    QUAD_NEG_FALL = 2'b11
  } quad_e;
  localparam int Q_SIZE = 128;
  localparam int Q_AMP = 127;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [7:0] LFSR_ZERO_SUB = 8'h01;
  localparam logic [2:0] MUTE_ATTEN = 3'd7;
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return s[0] ? (s >> 1) ^ LFSR_TAPS : s >> 1;
  endfunction
endpackage

// File: rtl/terrain_quarter_sine.sv
// terrain_quarter_sine: 128-entry quarter-sine magnitude, Q(0)=1 rising monotonically to Q(127)=127.
module terrain_quarter_sine (
  input  logic [6:0] idx,
  output logic [6:0] mag
);
  logic [13:0] prod;
  // Parabolic quarter wave: 1 + n*(254-n)/128 peaks at exactly 127 for n=127.
  assign prod = {7'd0, idx} * (14'd254 - {7'd0, idx});
  assign mag = 7'(prod >> 7) + 7'd1;
endmodule

// File: rtl/terrain_synth.sv
// terrain_synth: pipelined sum of sine octaves onto a base height, one saturated height per pixel column.
// Define TERRAIN_NOISE_EN to add the seeded LFSR noise term.
module terrain_synth
  import terrain_pkg::*;
#(
  parameter int NUM_OCT = 3,
  parameter int PHASE_W = 10,
  parameter int HEIGHT_W = 9,
  parameter int NOISE_SHIFT = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       line_start,
  input  logic                       pix_en,
  input  logic [NUM_OCT*PHASE_W-1:0] oct_offset,
  input  logic [NUM_OCT*3-1:0]       oct_step,
  input  logic [NUM_OCT*3-1:0]       oct_atten,
  input  logic [HEIGHT_W-1:0]        base_height,
  input  logic [7:0]                 seed,
  output logic [HEIGHT_W-1:0]        height,
  output logic                       height_valid
);
  localparam int SUM_W = HEIGHT_W + 3;
  logic signed [SUM_W-1:0] term [NUM_OCT];
  logic signed [SUM_W-1:0] sum;
  logic [HEIGHT_W-1:0] sat;
  logic [7:0] noise1;
  logic v1;
  for (genvar i = 0; i < NUM_OCT; i++) begin : g_oct
    logic [PHASE_W-1:0] phase, phase_eff;
    logic [6:0] n, mag, shifted;
    quad_e q;
    assign phase_eff = line_start ? oct_offset[i*PHASE_W +: PHASE_W] : phase;
    assign q = quad_e'(phase_eff[PHASE_W-1 -: 2]);
    assign n = (q == QUAD_FALL || q == QUAD_NEG_FALL) ? 7'(Q_SIZE - 1) - phase_eff[PHASE_W-3 -: 7]
                                                       : phase_eff[PHASE_W-3 -: 7];
    terrain_quarter_sine u_sine (.idx(n), .mag(mag));
    assign shifted = (oct_atten[i*3 +: 3] == MUTE_ATTEN) ? 7'd0 : mag >> oct_atten[i*3 +: 3];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        phase <= '0;
        term[i] <= '0;
      end else begin
        phase <= pix_en ? phase_eff + (PHASE_W'(1) << oct_step[i*3 +: 3]) : phase_eff;
        if (pix_en) term[i] <= (q == QUAD_NEG_RISE || q == QUAD_NEG_FALL) ? -SUM_W'(shifted) : SUM_W'(shifted);
      end
    end
  end
`ifdef TERRAIN_NOISE_EN
  logic [7:0] lfsr, lfsr_eff;
  // The sampled column uses the pre-step value; a reload and a step can share a cycle.
  assign lfsr_eff = line_start ? ((seed == 8'h00) ? LFSR_ZERO_SUB : seed) : lfsr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= 8'hFF;
      noise1 <= '0;
    end else begin
      lfsr <= pix_en ? lfsr_next(lfsr_eff) : lfsr_eff;
      if (pix_en) noise1 <= lfsr_eff >> NOISE_SHIFT;
    end
  end
`else
  logic unused_seed;
  assign unused_seed = ^seed;
  assign noise1 = '0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) v1 <= 1'b0;
    else v1 <= pix_en;
  end
  always_comb begin
    sum = SUM_W'(base_height) + SUM_W'(noise1);
    for (int k = 0; k < NUM_OCT; k++) sum = sum + term[k];
  end
  assign sat = sum[SUM_W-1] ? '0 : (|sum[SUM_W-2:HEIGHT_W]) ? {HEIGHT_W{1'b1}} : sum[HEIGHT_W-1:0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      height <= '0;
      height_valid <= 1'b0;
    end else begin
      height_valid <= v1;
      if (v1) height <= sat;
    end
  end
endmodule

// File: tb/tb_terrain_synth.sv
// tb_terrain_synth: directed checks of terrain_synth with hand-computed heights.
module tb_terrain_synth;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic line_start = 1'b0;
  logic pix_en = 1'b0;
  logic [29:0] oct_offset = '0;
  logic [8:0] oct_step = '0;
  logic [8:0] oct_atten = '1;
  logic [8:0] base_height = 9'd256;
  logic [7:0] seed = 8'h00;
  logic [8:0] height;
  logic height_valid;
  int n_tests = 0;
  int n_fail = 0;

  terrain_synth dut (
    .clk(clk), .rst_n(rst_n), .line_start(line_start), .pix_en(pix_en),
    .oct_offset(oct_offset), .oct_step(oct_step), .oct_atten(oct_atten),
    .base_height(base_height), .seed(seed), .height(height), .height_valid(height_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_oct(input int i, input int off, input int st, input int at);
    oct_offset[i*10 +: 10] = 10'(off);
    oct_step[i*3 +: 3] = 3'(st);
    oct_atten[i*3 +: 3] = 3'(at);
  endtask

  task automatic one_column(input string tag, input int exp);
    line_start = 1'b1;
    pix_en = 1'b1;
    tick();
    line_start = 1'b0;
    pix_en = 1'b0;
    check({tag, "_lat1"}, height_valid, 0);
    tick();
    check({tag, "_valid"}, height_valid, 1);
    check(tag, height, exp);
  endtask

  logic [7:0] m;
  int exp_q [300];

  initial begin
    int qoff [4] = '{0, 256, 512, 768};
    int qexp [4] = '{257, 383, 255, 129};
    #1 rst_n = 1'b0;
    #1;
    check("rst_height", height, 0);
    check("rst_valid", height_valid, 0);
    tick();
    rst_n = 1'b1;
    set_oct(0, 0, 0, 0);
    line_start = 1'b1;
    pix_en = 1'b1;
    tick();
    line_start = 1'b0;
    tick();
    tick();
    check("stream_valid", height_valid, 1);
    check("stream_height", height, 257);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_height", height, 0);
    check("midrst_valid", height_valid, 0);
    pix_en = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("postrst_idle", height_valid, 0);
    pix_en = 1'b1;
    tick();
    pix_en = 1'b0;
    check("postrst_lat1", height_valid, 0);
    tick();
    check("postrst_valid", height_valid, 1);
    check("postrst_height", height, 257);

    for (int k = 0; k < 4; k++) begin
      set_oct(0, qoff[k], 0, 0);
      one_column($sformatf("quad%0d", k), qexp[k]);
    end

    set_oct(0, 1020, 2, 0);
    line_start = 1'b1;
    pix_en = 1'b1;
    tick();
    line_start = 1'b0;
    tick();
    check("wrap0_valid", height_valid, 1);
    check("wrap0", height, 254);
    tick();
    pix_en = 1'b0;
    check("wrap1", height, 257);
    tick();
    check("wrap2_valid", height_valid, 1);
    check("wrap2", height, 260);
    tick();
    check("wrap_end", height_valid, 0);
    check("wrap_hold", height, 260);

    for (int k = 0; k < 3; k++) set_oct(k, 256, 0, 0);
    base_height = 9'd500;
    one_column("sat_hi", 511);
    for (int k = 0; k < 3; k++) set_oct(k, 768, 0, 0);
    base_height = 9'd10;
    one_column("sat_lo", 0);
    base_height = 9'd256;
    set_oct(1, 0, 0, 7);
    set_oct(2, 0, 0, 7);

    set_oct(0, 0, 3, 0);
    line_start = 1'b1;
    pix_en = 1'b1;
    tick();
    line_start = 1'b0;
    pix_en = 1'b0;
    tick();
    check("gap_v0", height_valid, 1);
    check("gap_h0", height, 257);
    tick();
    pix_en = 1'b1;
    check("gap_idle1", height_valid, 0);
    tick();
    pix_en = 1'b0;
    check("gap_idle2", height_valid, 0);
    check("gap_hold", height, 257);
    tick();
    check("gap_v1", height_valid, 1);
    check("gap_h1", height, 264);

    set_oct(0, 0, 0, 0);
    seed = 8'hC0;
`ifdef TERRAIN_NOISE_EN
    one_column("noise_c0", 260);
`else
    one_column("noise_c0", 257);
`endif
    seed = 8'h00;
    one_column("noise_zero", 257);

    set_oct(0, 0, 0, 7);
    seed = 8'h5A;
    m = seed;
    for (int k = 0; k < 300; k++) begin
`ifdef TERRAIN_NOISE_EN
      exp_q[k] = 256 + int'(m >> 6);
      m = m[0] ? (m >> 1) ^ 8'hB8 : m >> 1;
`else
      exp_q[k] = 256;
`endif
    end
    for (int k = 0; k < 301; k++) begin
      line_start = (k == 0);
      pix_en = (k < 300);
      tick();
      if (k >= 1) check($sformatf("lfsr%0d", k - 1), height, exp_q[k-1]);
    end
    line_start = 1'b0;
    pix_en = 1'b0;
    tick();
    check("lfsr_last", height, exp_q[299]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/terrain_synth.md
Name: terrain_synth

Overview:
- Streaming, pipelined terrain-height synthesiser for the VGA tank game.
- Sums NUM_OCT independently phased, stepped and attenuated sine octaves onto a base height. Emits one saturated height per pixel column.
- Sits between the hvsync generator and the pixel colour mux: the line-start pulse comes from the blanking interval, and the pixel enable comes from the active-video strobe.

Parameters:
- NUM_OCT, 3, number of sine octaves
- PHASE_W, 10, phase accumulator width (must be >= 9)
- HEIGHT_W, 9, output height width
- NOISE_SHIFT, 6, right shift applied to the LFSR noise term (optional feature only)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- line_start  in  1  reload phase accumulators (and LFSR) for column 0
- pix_en  in  1  sample the current column and advance one column
- oct_offset  in  NUM_OCT*PHASE_W  packed per-octave start phase; octave i is at [i*PHASE_W +: PHASE_W]
- oct_step  in  NUM_OCT*3  per-octave step exponent; phase increment = 1<<step
- oct_atten  in  NUM_OCT*3  per-octave right shift of magnitude; 7 effectively mutes the octave
- base_height  in  HEIGHT_W  unsigned centre height
- seed  in  8  LFSR seed; always present, ignored unless the noise feature is compiled in
- height  out  HEIGHT_W  registered terrain height
- height_valid  out  1  height corresponds to a sampled column

Behaviour:
- Reset (async, rst_n=0): all phases 0, all pipeline registers 0, height=0, height_valid=0, LFSR=8'hFF. Effect is immediate, including mid-line. After release, no output until the next pix_en.
- Stage 0, per octave:
  - phase_eff = line_start ? offset_i : phase_i.
  - If pix_en: phase_i <= phase_eff + (1<<step_i) mod 2^PHASE_W. Otherwise phase_i <= phase_eff.
  - line_start and pix_en in the same cycle: column 0 (the offset) is sampled and the phase becomes offset+step.
  - line_start alone: reloads only, emits nothing.
- Sine fold from phase_eff:
  - quadrant q = phase_eff[PHASE_W-1:PHASE_W-2].
  - Index n = phase_eff[PHASE_W-3 -: 7]; mirrored to 127-n when q[0]=1.
  - Sign negative when q[1]=1.
  - Magnitude = Q(n): the codebase's 128-entry quarter-sine table, Q(0)=1, Q(127)=127, monotonic non-decreasing.
- Stage 1 (registered on pix_en): per-octave signed term = ±(Q >> atten_i); v1 <= pix_en.
- Stage 2 (registered): sum = base_height + Σ terms, computed signed at HEIGHT_W+3 bits. Saturate to [0, 2^HEIGHT_W-1]. height_valid <= v1.
- Latency: the column sampled at pix_en in cycle t appears at t+2.
- One result per pix_en; back-to-back pix_en gives one result per cycle.
- Gaps in pix_en hold all phases and produce no valid output.
- height holds its last value while height_valid=0.
- Inputs offset/step/atten/base are sampled live. Changes mid-line take effect from the next sample; no glitch protection is required.

Optional Feature:
- Macro TERRAIN_NOISE_EN.
- Defined:
  - An 8-bit Galois LFSR (x^8+x^6+x^5+x^4+1) loads seed on line_start; seed 8'h00 loads 8'h01.
  - It steps once per pix_en; with line_start and pix_en together it loads the seed and then steps.
  - The pre-step value of the sampled column is used. Stage 1 registers (lfsr >> NOISE_SHIFT), which is added unsigned in stage 2 before saturation.
- Undefined: no LFSR, the noise term is 0, and seed is unused. Latency is identical in both builds.

Decomposition:
- Package terrain_pkg:
  - quadrant encoding constants;
  - Q table size (128) and amplitude (127);
  - LFSR tap mask 8'hB8 and zero-seed substitute 8'h01;
  - MUTE_ATTEN=7.
- Sub-module terrain_quarter_sine: combinational 7-bit index -> 7-bit magnitude table, instantiated once per octave.

Test Plan:
All scenarios use default parameters, octaves 1..2 muted (atten 7) unless stated, and base 256.
- Reset mid-stream: pix_en streaming, rst_n driven low -> height=0, height_valid=0 in the same cycle; after release, no valid until 2 cycles after the next pix_en.
- Quadrants: octave 0 offset 0/256/512/768, step 0, atten 0, single line_start+pix_en -> height 257/383/255/129 exactly 2 cycles later.
- Wrap: offset 1020, step 2, three consecutive pix_en -> sampled phases 1020, 0, 4. Second result = 257.
- Saturation: all octaves offset 256, atten 0:
  - base 500 -> 511.
  - All octaves offset 768, base 10 -> 0.
- Gaps and hold: pix_en pattern 1,0,0,1 with step 3 -> two valids, at cycles t+2 and t+5. Second sample uses phase 8; height holds between valids.
- TERRAIN_NOISE_EN: seed 8'hC0, offset 0, base 256 -> first height 260 (257+3).
  - Seed 0 -> noise term 0 on the first sample.
  - LFSR sequence matches the Galois model for 300 pix_en.
